// File: rtl/crc_stream_pkg.sv
// Shared types, presets and helpers for the streaming CRC engine.
package crc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] poly;
        logic [31:0] init;
        logic [31:0] xorout;
        logic        refin;
        logic        refout;
        logic [31:0] residue;
    } crc_preset_t;

    localparam crc_preset_t CRC16_BUYPASS = '{
        poly: 32'h8005, init: 32'h0, xorout: 32'h0,
        refin: 1'b0, refout: 1'b0, residue: 32'h0
    };

    localparam crc_preset_t CRC16_ARC = '{
        poly: 32'h8005, init: 32'h0, xorout: 32'h0,
        refin: 1'b1, refout: 1'b1, residue: 32'h0
    };

    localparam crc_preset_t CRC16_CCITT_FALSE = '{
        poly: 32'h1021, init: 32'hFFFF, xorout: 32'h0,
        refin: 1'b0, refout: 1'b0, residue: 32'h0
    };

    localparam crc_preset_t CRC32 = '{
        poly: 32'h04C11DB7, init: 32'hFFFFFFFF, xorout: 32'hFFFFFFFF,
        refin: 1'b1, refout: 1'b1, residue: 32'hC704DD7B
    };

    // Reverse the low w bits of v; result is right-justified.
    function automatic logic [31:0] bitrev(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] t;
        t = {<<{v}};
        return t >> (32 - w);
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational single-byte CRC update, MSB-first bit-serial form.
module crc_byte_step
    import crc_stream_pkg::*;
#(
    parameter int              CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY = '0,
    parameter bit              REFIN = 1'b0
) (
    input  logic [CRC_W-1:0] reg_in,
    input  logic [7:0]       data,
    input  logic             enable,
    output logic [CRC_W-1:0] reg_out
);

    logic [7:0]       b;
    logic [CRC_W-1:0] r;
    logic             fb;

    always_comb begin
        b  = REFIN ? 8'(bitrev(32'(data), 8)) : data;
        r  = reg_in;
        fb = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ b[i];
            r  = (r << 1) ^ (fb ? POLY : '0);
        end
        reg_out = enable ? r : reg_in;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker with frame delimiting and result handshake.
module crc_stream_engine
    import crc_stream_pkg::*;
#(
    parameter int          CRC_W   = 16,
    parameter logic [31:0] POLY    = 32'h8005,
    parameter logic [31:0] INIT    = 32'h0,
    parameter logic [31:0] XOROUT  = 32'h0,
    parameter bit          REFIN   = 1'b0,
    parameter bit          REFOUT  = 1'b0,
    parameter int          DATA_W  = 8,
    parameter logic [31:0] RESIDUE = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_sof,
    input  logic                in_last,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CRC_W-1:0]    out_crc,
    output logic                out_ok,
    output logic                err_proto
);

    localparam int LANES = DATA_W / 8;
    localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_W  = XOROUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] RES_W  = RESIDUE[CRC_W-1:0];

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] out_crc_q, out_crc_d;
    logic             out_ok_q, out_ok_d;
    logic             err_q, err_d;

    logic             accept;
    logic [LANES-1:0] lane_en;
    logic [CRC_W-1:0] chain [LANES+1];
    logic [CRC_W-1:0] nxt;
    logic [CRC_W-1:0] fin;

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_crc   = out_crc_q;
    assign out_ok    = out_ok_q;
    assign err_proto = err_q;
    assign accept    = in_valid && in_ready;

    // Keep only trims the tail of the frame.
    assign lane_en  = in_last ? in_keep : '1;
    assign chain[0] = in_sof ? INIT_W : crc_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        crc_byte_step #(
            .CRC_W(CRC_W),
            .POLY (POLY_W),
            .REFIN(REFIN)
        ) u_step (
            .reg_in (chain[g]),
            .data   (in_data[8*g +: 8]),
            .enable (lane_en[g]),
            .reg_out(chain[g+1])
        );
    end

    assign nxt = chain[LANES];
    assign fin = (REFOUT ? CRC_W'(bitrev(32'(nxt), CRC_W)) : nxt) ^ XOR_W;

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        out_crc_d = out_crc_q;
        out_ok_d  = out_ok_q;
        err_d     = 1'b0;
        if (abort) begin
            state_d = IDLE;
            crc_d   = INIT_W;
        end else begin
            case (state_q)
                IDLE, RUN: begin
                    if (accept) begin
                        if (!in_sof && state_q == IDLE) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = in_sof && (state_q == RUN);
                            crc_d = nxt;
                            if (in_last) begin
                                state_d   = DONE;
                                out_crc_d = fin;
                                out_ok_d  = (nxt == RES_W);
                            end else begin
                                state_d = RUN;
                            end
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        crc_d   = INIT_W;
                    end
                end
                default: begin
                    state_d = IDLE;
                    crc_d   = INIT_W;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            crc_q     <= INIT_W;
            out_crc_q <= '0;
            out_ok_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            out_crc_q <= out_crc_d;
            out_ok_q  <= out_ok_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: BUYPASS and ARC on one byte stream, CRC-32 on a 32-bit stream.
module tb_crc_stream_engine;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int           len;
        logic [103:0] data;
        bit           has_bp;
        logic [15:0]  bp_crc;
        bit           bp_ok;
        bit           has_arc;
        logic [15:0]  arc_crc;
        bit           arc_ok;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    logic out_ready = 1'b0;

    logic       v8 = 1'b0, s8 = 1'b0, l8 = 1'b0;
    logic [7:0] d8 = '0;
    logic [0:0] k8 = 1'b1;
    logic        rdy_bp, ov_bp, ok_bp, err_bp;
    logic [15:0] crc_bp;
    logic        rdy_arc, ov_arc, ok_arc, err_arc;
    logic [15:0] crc_arc;

    logic        v32 = 1'b0, s32 = 1'b0, l32 = 1'b0;
    logic [31:0] d32 = '0;
    logic [3:0]  k32 = '1;
    logic        rdy32, ov32, ok32, err32;
    logic [31:0] crc32;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    crc_stream_engine #(
        .CRC_W(16), .POLY(32'h8005), .INIT(32'h0), .XOROUT(32'h0),
        .REFIN(1'b0), .REFOUT(1'b0), .DATA_W(8), .RESIDUE(32'h0)
    ) u_bp (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy_bp),
        .in_data(d8), .in_keep(k8), .in_sof(s8), .in_last(l8),
        .abort(abort), .out_valid(ov_bp), .out_ready(out_ready),
        .out_crc(crc_bp), .out_ok(ok_bp), .err_proto(err_bp)
    );

    crc_stream_engine #(
        .CRC_W(16), .POLY(32'h8005), .INIT(32'h0), .XOROUT(32'h0),
        .REFIN(1'b1), .REFOUT(1'b1), .DATA_W(8), .RESIDUE(32'h0)
    ) u_arc (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy_arc),
        .in_data(d8), .in_keep(k8), .in_sof(s8), .in_last(l8),
        .abort(abort), .out_valid(ov_arc), .out_ready(out_ready),
        .out_crc(crc_arc), .out_ok(ok_arc), .err_proto(err_arc)
    );

    crc_stream_engine #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .XOROUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1),
        .DATA_W(32), .RESIDUE(32'hC704DD7B)
    ) u_32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
        .in_data(d32), .in_keep(k32), .in_sof(s32), .in_last(l32),
        .abort(abort), .out_valid(ov32), .out_ready(out_ready),
        .out_crc(crc32), .out_ok(ok32), .err_proto(err32)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = v[w-1-i];
        return r;
    endfunction

    // Byte-at-a-time polynomial division, reflection applied around it.
    task automatic model(input int w, input logic [31:0] poly,
                         input logic [31:0] init, input logic [31:0] xo,
                         input logic [31:0] res, input bit ri, input bit ro,
                         input bq_t q, output logic [31:0] crc,
                         output bit ok);
        logic [63:0] m, r;
        logic [31:0] f;
        m = (64'd1 << w) - 64'd1;
        r = 64'(init) & m;
        foreach (q[k]) begin
            logic [7:0] b;
            b = ri ? 8'(rev(32'(q[k]), 8)) : q[k];
            r = r ^ (64'(b) << (w - 8));
            repeat (8) r = r[w-1] ? (((r << 1) ^ 64'(poly)) & m) : ((r << 1) & m);
        end
        ok  = (r[31:0] == res);
        f   = ro ? rev(r[31:0], w) : r[31:0];
        crc = (f ^ xo) & m[31:0];
    endtask

    task automatic beat8(input logic [7:0] b, input bit sof, input bit last);
        v8 = 1'b1; d8 = b; s8 = sof; l8 = last;
        @(posedge clk); #1;
        v8 = 1'b0; s8 = 1'b0; l8 = 1'b0;
    endtask

    task automatic send8(input bq_t q);
        foreach (q[k]) beat8(q[k], k == 0, k == q.size() - 1);
    endtask

    task automatic chk8(input bq_t q, input string tag);
        logic [31:0] c;
        bit o;
        model(16, 32'h8005, 0, 0, 0, 0, 0, q, c, o);
        check({tag, "_bp_valid"}, 32'(ov_bp), 1);
        check({tag, "_bp_crc"}, 32'(crc_bp), c);
        check({tag, "_bp_ok"}, 32'(ok_bp), 32'(o));
        model(16, 32'h8005, 0, 0, 0, 1, 1, q, c, o);
        check({tag, "_arc_valid"}, 32'(ov_arc), 1);
        check({tag, "_arc_crc"}, 32'(crc_arc), c);
        check({tag, "_arc_ok"}, 32'(ok_arc), 32'(o));
    endtask

    task automatic send32(input bq_t q, input bit empty_tail);
        int idx, cnt, n;
        bit last;
        n = q.size();
        idx = 0;
        while (idx < n) begin
            cnt  = (n - idx > 4) ? 4 : n - idx;
            last = (idx + cnt == n) && !empty_tail;
            d32  = $urandom;
            for (int j = 0; j < cnt; j++) d32[8*j +: 8] = q[idx+j];
            k32  = last ? 4'((5'd1 << cnt) - 5'd1) : 4'($urandom);
            v32 = 1'b1; s32 = (idx == 0); l32 = last;
            @(posedge clk); #1;
            idx += cnt;
        end
        if (empty_tail) begin
            d32 = $urandom; k32 = 4'b0000;
            v32 = 1'b1; s32 = 1'b0; l32 = 1'b1;
            @(posedge clk); #1;
        end
        v32 = 1'b0; s32 = 1'b0; l32 = 1'b0;
    endtask

    task automatic chk32(input bq_t q, input string tag);
        logic [31:0] c;
        bit o;
        model(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hC704DD7B, 1, 1, q, c, o);
        check({tag, "_32_valid"}, 32'(ov32), 1);
        check({tag, "_32_crc"}, crc32, c);
        check({tag, "_32_ok"}, 32'(ok32), 32'(o));
    endtask

    task automatic take(input bit wide, input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        if (wide) begin
            check({tag, "_take_rdy32"}, 32'(rdy32), 1);
            check({tag, "_take_ov32"}, 32'(ov32), 0);
        end else begin
            check({tag, "_take_rdy"}, 32'(rdy_bp), 1);
            check({tag, "_take_ov"}, 32'(ov_bp), 0);
        end
    endtask

    function automatic bq_t rand_q(input int lo, input int hi);
        bq_t q;
        int n;
        n = $urandom_range(hi, lo);
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        vec_t vt[4];
        bq_t s123, q;

        s123 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        vt[0] = '{9, {32'd0, "123456789"}, 1, 16'hFEE8, 0, 1, 16'hBB3D, 0};
        vt[1] = '{11, {16'd0, "123456789", 8'h3D, 8'hBB}, 0, 16'h0, 0, 1, 16'h0000, 1};
        vt[2] = '{11, {16'd0, "123456789", 8'hFE, 8'hE8}, 1, 16'h0000, 1, 0, 16'h0, 0};
        vt[3] = '{1, {96'd0, 8'h00}, 1, 16'h0000, 1, 1, 16'h0000, 1};

        #12 rst = 1'b0;
        @(negedge clk);
        check("rst_ov", 32'(ov_bp), 0);
        check("rst_crc", 32'(crc_bp), 0);
        check("rst_ok", 32'(ok_bp), 0);
        check("rst_err", 32'(err_bp), 0);
        check("rst_rdy", 32'(rdy_bp), 1);
        check("rst_rdy32", 32'(rdy32), 1);
        check("rst_ov32", 32'(ov32), 0);

        for (int i = 0; i < 4; i++) begin
            q = {};
            for (int k = 0; k < vt[i].len; k++)
                q.push_back(vt[i].data[8*(vt[i].len-1-k) +: 8]);
            send8(q);
            @(negedge clk);
            chk8(q, $sformatf("vec%0d", i));
            if (vt[i].has_bp) begin
                check($sformatf("vec%0d_bp_crc_k", i), 32'(crc_bp), 32'(vt[i].bp_crc));
                check($sformatf("vec%0d_bp_ok_k", i), 32'(ok_bp), 32'(vt[i].bp_ok));
            end
            if (vt[i].has_arc) begin
                check($sformatf("vec%0d_arc_crc_k", i), 32'(crc_arc), 32'(vt[i].arc_crc));
                check($sformatf("vec%0d_arc_ok_k", i), 32'(ok_arc), 32'(vt[i].arc_ok));
            end
            take(0, $sformatf("vec%0d", i));
        end

        // Consumer stall, then an immediate follow-up frame.
        send8(s123);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rdy", 32'(rdy_bp), 0);
            check("stall_ov", 32'(ov_bp), 1);
            check("stall_crc", 32'(crc_bp), 32'h FEE8);
        end
        take(0, "stall");
        q = rand_q(1, 10);
        send8(q);
        @(negedge clk);
        chk8(q, "after_stall");
        take(0, "after_stall");

        // Beat without sof in IDLE.
        beat8(8'h55, 0, 1);
        @(negedge clk);
        check("nosof_err", 32'(err_bp), 1);
        check("nosof_err_arc", 32'(err_arc), 1);
        check("nosof_ov", 32'(ov_bp), 0);
        @(negedge clk);
        check("nosof_err_once", 32'(err_bp), 0);
        check("nosof_ov2", 32'(ov_bp), 0);

        // sof mid-frame restarts the frame.
        beat8(8'h41, 1, 0);
        beat8(8'h42, 0, 0);
        beat8(s123[0], 1, 0);
        @(negedge clk);
        check("restart_err", 32'(err_bp), 1);
        for (int k = 1; k < 9; k++) beat8(s123[k], 0, k == 8);
        @(negedge clk);
        check("restart_err_clr", 32'(err_bp), 0);
        check("restart_crc", 32'(crc_bp), 32'hFEE8);
        chk8(s123, "restart");
        take(0, "restart");

        // Abort mid-frame, with a beat presented alongside.
        q = rand_q(4, 4);
        foreach (q[k]) beat8(q[k], k == 0, 0);
        abort = 1'b1;
        beat8(8'h31, 1, 1);
        abort = 1'b0;
        @(negedge clk);
        check("abort_run_ov", 32'(ov_bp), 0);
        check("abort_run_rdy", 32'(rdy_bp), 1);
        @(negedge clk);
        check("abort_run_ov2", 32'(ov_bp), 0);
        send8(s123);
        @(negedge clk);
        check("abort_run_next", 32'(crc_bp), 32'hFEE8);
        take(0, "abort_run");

        // Abort while holding a result.
        send8(rand_q(2, 6));
        @(negedge clk);
        check("abort_done_pre", 32'(ov_bp), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_done_ov", 32'(ov_bp), 0);
        check("abort_done_rdy", 32'(rdy_bp), 1);
        send8(s123);
        @(negedge clk);
        check("abort_done_next", 32'(crc_bp), 32'hFEE8);
        take(0, "abort_done");

        // Asynchronous reset mid-frame and mid-result.
        q = rand_q(3, 3);
        foreach (q[k]) beat8(q[k], k == 0, 0);
        #2 rst = 1'b1;
        #1 check("rst_run_ov", 32'(ov_bp), 0);
        check("rst_run_rdy", 32'(rdy_bp), 1);
        #1 rst = 1'b0;
        send8(s123);
        @(negedge clk);
        check("rst_run_next", 32'(crc_bp), 32'hFEE8);
        #2 rst = 1'b1;
        #1 check("rst_done_ov", 32'(ov_bp), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_done_ov2", 32'(ov_bp), 0);
        send8(s123);
        @(negedge clk);
        check("rst_done_next", 32'(crc_bp), 32'hFEE8);
        take(0, "rst_done");

        // CRC-32 on 32-bit beats.
        send32(s123, 0);
        @(negedge clk);
        check("c32_check", crc32, 32'hCBF43926);
        chk32(s123, "c32");
        take(1, "c32");
        q = s123;
        q.push_back(8'h26); q.push_back(8'h39);
        q.push_back(8'hF4); q.push_back(8'hCB);
        send32(q, 0);
        @(negedge clk);
        check("c32_res_ok", 32'(ok32), 1);
        check("c32_res_crc", crc32, 32'h2144DF1C);
        take(1, "c32_res");

        for (int i = 0; i < 20; i++) begin
            q = rand_q(1, 12);
            send8(q);
            @(negedge clk);
            chk8(q, $sformatf("rnd8_%0d", i));
            repeat ($urandom_range(2, 0)) @(negedge clk);
            take(0, $sformatf("rnd8_%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            q = rand_q(1, 14);
            send32(q, (q.size() % 4 == 0) && ($urandom_range(1, 0) == 1));
            @(negedge clk);
            chk32(q, $sformatf("rnd32_%0d", i));
            take(1, $sformatf("rnd32_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
Parametrised, streaming CRC generator and checker. It succeeds the fixed 16-bit, 8-bit-wide serial CRC block. Polynomial, width, init, reflection, final XOR and datapath width are all parameters. It adds frame delimiting (sof/last), byte-enables on the last beat, abort, a valid/ready result handshake, and a residue-based check result. It sits between a byte-stream source (UART/packet framer) and a consumer that appends or verifies the CRC.

Parameters:
CRC_W, 16, CRC register width (8..32)
POLY, 16'h8005, generator polynomial without the x^CRC_W term
INIT, 0, register value at frame start
XOROUT, 0, value XORed onto the final (post-reflect) CRC
REFIN, 0, 1 = bit-reverse each input byte before processing
REFOUT, 0, 1 = bit-reverse the final register before XOROUT
DATA_W, 8, input beat width; must be a multiple of 8 (8..64)
RESIDUE, 0, raw register value meaning "frame plus appended CRC is good"

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  DATA_W  beat data; byte lane 0 = bits [7:0], processed first
in_keep  in  DATA_W/8  byte enables; honoured on the last beat only
in_sof  in  1  beat is the first of a frame
in_last  in  1  beat is the last of a frame
abort  in  1  synchronous frame abort
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_crc  out  CRC_W  final CRC after REFOUT and XOROUT
out_ok  out  1  raw register == RESIDUE
err_proto  out  1  one-cycle pulse on a framing violation

Behaviour:
- Beat accepted when in_valid && in_ready. in_ready depends on state only, never on in_valid.
- Step function, per enabled lane in ascending order:
  - b = REFIN ? bitrev8(byte) : byte.
  - For i = 7 downto 0: fb = reg[CRC_W-1] ^ b[i]; reg = (reg << 1) ^ (fb ? POLY : 0).
- All enabled lanes are processed in one cycle; the whole update is combinational.
- Keep handling:
  - Non-last beats: keep is ignored; all lanes are enabled.
  - Last beat: keep must be contiguous from lane 0. keep = 0 leaves the register unchanged.
  - Non-contiguous keep: behaviour is undefined; the bench must not drive it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1.
    - Beat with sof: reg <= step(INIT, beat). Go to DONE if last, else RUN.
    - Beat without sof: dropped, err_proto pulses, stay in IDLE.
  - RUN: in_ready = 1.
    - Beat without sof: reg <= step(reg, beat). Go to DONE if last.
    - Beat with sof: restart, reg <= step(INIT, beat), err_proto pulses. Go to DONE if last, else RUN.
  - DONE: in_ready = 0, out_valid = 1.
    - out_crc and out_ok are registered and stable while out_valid is high.
    - On out_valid && out_ready: go to IDLE, reg <= INIT.
- Latency: out_valid rises on the clock edge after the last beat is accepted. Back-to-back frames therefore lose at least one cycle in DONE.
- out_ok compares the raw register (pre-REFOUT, pre-XOROUT) with RESIDUE.
- abort has the highest priority in any state: go to IDLE, reg <= INIT, out_valid <= 0, any pending result is discarded. A beat presented in the same cycle as abort is ignored.
- Reset values: state IDLE, reg INIT, out_valid 0, out_crc 0, out_ok 0, err_proto 0. in_ready = 1 immediately after reset deasserts.
- Reset mid-frame or mid-DONE discards everything; no partial result is emitted.
- No idle-cycle bubbles are required: one beat per clock is sustained in RUN.

Decomposition:
- Package crc_stream_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - function bitrev (generic width);
  - constants for common presets: CRC16_BUYPASS, CRC16_ARC, CRC16_CCITT_FALSE, CRC32 (poly/init/xorout/refin/refout/residue).
- One sub-module, crc_byte_step: combinational single-byte update (reg_in, byte, enable -> reg_out). It is instantiated DATA_W/8 times in a chain; the top keeps the FSM and output registers.

Test Plan:
- Defaults (CRC-16/BUYPASS), "123456789" as 9 single-byte beats, sof on beat 0, last on beat 8 -> out_crc 16'hFEE8, out_valid one cycle after the last beat.
- REFIN = REFOUT = 1 (CRC-16/ARC), same string -> 16'hBB3D. Then send string plus bytes 3D, BB -> out_ok = 1 with RESIDUE 0.
- CRC_W = 32, POLY 04C11DB7, INIT / XOROUT FFFFFFFF, REFIN = REFOUT = 1, DATA_W = 32; "123456789" in 3 beats, last keep 4'b0001 -> 32'hCBF43926. Appending its 4 CRC bytes -> out_ok = 1 with RESIDUE 32'hC704DD7B.
- Handshake: hold out_ready = 0 for 5 cycles -> in_ready stays 0, out_crc stable. Then out_ready = 1 -> IDLE next cycle. A frame sent immediately after gives the correct CRC with no carry-over.
- Framing errors:
  - Beat without sof in IDLE -> err_proto pulses once, no result.
  - sof mid-frame -> err_proto pulses, CRC equals that of the restarted frame alone.
- abort mid-frame, and abort while in DONE -> out_valid 0 next cycle, no result emitted. The next frame gives 16'hFEE8 for "123456789". Asynchronous rst mid-frame produces the same outcome.
